// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory-port arbiter.
package mem_arb_pkg;

    localparam int LINE_W_DFLT = 256;
    localparam int BEAT_W_DFLT = 64;
    localparam int BEATS       = LINE_W_DFLT / BEAT_W_DFLT;
    localparam int LINE_OFFSET = 5;   // log2 of line size in bytes

    // Arbiter FSM encoding, kept as plain constants for older tools
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t READ  = 2'd1;
    localparam arb_state_t WRITE = 2'd2;
    localparam arb_state_t DONE  = 2'd3;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef logic [LINE_W_DFLT-1:0] line_t;
    typedef logic [BEAT_W_DFLT-1:0] beat_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one line-level transfer into a burst of NBEATS memory beats.
// A single-cycle start launches the burst; done pulses combinationally on the
// cycle the final beat is accepted, with rline already holding that beat.
module cacheline_adaptor
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = LINE_W_DFLT,
    parameter int BEAT_W = BEAT_W_DFLT,
    parameter int NBEATS = BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_write,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LINE_W-1:0] start_line,
    output logic              done,
    output logic [LINE_W-1:0] rline,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BEAT_W-1:0] mem_burst_o,
    input  logic [BEAT_W-1:0] mem_burst_i,
    input  logic              mem_resp
);

    localparam int K_W = $clog2(NBEATS);

    logic [K_W-1:0]    k;
    logic [K_W-1:0]    k_nxt;
    logic [LINE_W-1:0] line;
    logic              beat;
    logic              last_beat;

    // Beats only count while a burst is in flight; stray mem_resp is ignored
    assign beat      = (mem_read | mem_write) & mem_resp;
    assign last_beat = (k == K_W'(NBEATS - 1));
    assign k_nxt     = k + 1'b1;
    assign done      = beat & last_beat;

    // Line as it will look once the current beat is stored
    always_comb begin
        rline = line;
        rline[BEAT_W*int'(k) +: BEAT_W] = mem_burst_i;
    end

    // Burst handshake, beat counter and line assembly / shift-out
    always_ff @(posedge clk) begin
        if (rst) begin
            k           <= '0;
            line        <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_burst_o <= '0;
        end else if (start) begin
            k           <= '0;
            mem_read    <= ~start_write;
            mem_write   <= start_write;
            mem_address <= start_addr & ~ADDR_W'((1 << LINE_OFFSET) - 1);
            if (start_write) begin
                line        <= start_line;
                mem_burst_o <= start_line[BEAT_W-1:0];
            end else begin
                line <= '0;
            end
        end else if (beat) begin
            k <= k_nxt;
            if (mem_read)
                line[BEAT_W*int'(k) +: BEAT_W] <= mem_burst_i;
            else if (!last_beat)
                mem_burst_o <= line[BEAT_W*int'(k_nxt) +: BEAT_W];
            if (last_beat) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between I$ and D$ misses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = $bits(line_t),
    parameter int BEAT_W = $bits(beat_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BEAT_W-1:0] mem_burst_o,
    input  logic [BEAT_W-1:0] mem_burst_i,
    input  logic              mem_resp
);

    arb_state_t        state;
    port_t             gnt_port;
    port_t             last_served;
    logic              gnt_write;
    logic              pend_i;
    logic              pend_d;
    logic              grant_d;
    logic              start;
    logic              start_write;
    logic [ADDR_W-1:0] start_addr;
    logic              xfer_done;
    logic [LINE_W-1:0] rline;

    // D wins when alone or when I was served last; d_write beats d_read
    assign pend_i      = i_read;
    assign pend_d      = d_read | d_write;
    assign grant_d     = pend_d & (~pend_i | (last_served == PORT_I));
    assign start       = (state == IDLE) & (pend_i | pend_d);
    assign start_write = grant_d & d_write;
    assign start_addr  = grant_d ? d_address : i_address;

    cacheline_adaptor #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .NBEATS (LINE_W / BEAT_W)
    ) u_adaptor (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_write (start_write),
        .start_addr  (start_addr),
        .start_line  (d_wdata),
        .done        (xfer_done),
        .rline       (rline),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_burst_o (mem_burst_o),
        .mem_burst_i (mem_burst_i),
        .mem_resp    (mem_resp)
    );

    // Grant FSM, response pulse and per-port read data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt_port    <= PORT_I;
            gnt_write   <= 1'b0;
            last_served <= PORT_I;
            i_resp      <= 1'b0;
            d_resp      <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        gnt_port  <= grant_d ? PORT_D : PORT_I;
                        gnt_write <= start_write;
                        state     <= start_write ? WRITE : READ;
                    end
                end
                READ, WRITE: begin
                    if (xfer_done) begin
                        state <= DONE;
                        if (gnt_port == PORT_D) begin
                            d_resp <= 1'b1;
                            if (!gnt_write)
                                d_rdata <= rline;
                        end else begin
                            i_resp  <= 1'b1;
                            i_rdata <= rline;
                        end
                    end
                end
                DONE: begin
                    last_served <= gnt_port;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-level transaction model.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef logic [LINE_W-1:0] cv_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [BEAT_W-1:0] mem_burst_o;
    logic [BEAT_W-1:0] mem_burst_i;
    logic              mem_resp;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_burst_o (mem_burst_o),
        .mem_burst_i (mem_burst_i),
        .mem_resp    (mem_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, cv_t got, cv_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // stimulus knobs
    bit auto_i, auto_d;
    int req_pct, resp_pct, stray_pct;

    // requester state
    bit                i_pend, d_pend, d_wr, d_both;
    logic [ADDR_W-1:0] i_addr_r, d_addr_r;
    logic [LINE_W-1:0] d_wdata_r;
    int                resp_log[$];   // 0 = I, 1 = D, in completion order

    // backing memory: line-address -> line
    logic [LINE_W-1:0] mem_q [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] wcap;

    // reference model
    bit                m_busy, m_wr, m_port, m_last, m_resp_i, m_resp_d;
    int                m_beat;
    logic [ADDR_W-1:0] m_addr, m_maddr;
    logic [LINE_W-1:0] m_line, m_rd_i, m_rd_d;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int w = 0; w < LINE_W / 32; w++) l[32*w +: 32] = $urandom();
        return l;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'(32'h4000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31));
    endfunction

    function automatic logic [LINE_W-1:0] line_of(logic [ADDR_W-1:0] a);
        if (!mem_q.exists(a)) mem_q[a] = rand_line();
        return mem_q[a];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_port = 0; m_last = 0; m_resp_i = 0; m_resp_d = 0;
        m_beat = 0; m_addr = '0; m_maddr = '0; m_line = '0; m_rd_i = '0; m_rd_d = '0;
    endtask

    task automatic drive_req();
        i_read    = i_pend;
        i_address = i_addr_r;
        d_read    = d_pend && (!d_wr || d_both);
        d_write   = d_pend && d_wr;
        d_address = d_addr_r;
        d_wdata   = d_wdata_r;
    endtask

    // One clock: compare outputs, react as requesters/memory, advance model
    task automatic cycle();
        bit n_i, n_d, pi, pd;
        int idx;
        logic [LINE_W-1:0] tmp;
        check("i_resp", cv_t'(i_resp), cv_t'(m_resp_i));
        check("d_resp", cv_t'(d_resp), cv_t'(m_resp_d));
        check("mem_read", cv_t'(mem_read), cv_t'(m_busy && !m_wr));
        check("mem_write", cv_t'(mem_write), cv_t'(m_busy && m_wr));
        check("mem_address", cv_t'(mem_address), cv_t'(m_maddr));
        check("i_rdata", i_rdata, m_rd_i);
        check("d_rdata", d_rdata, m_rd_d);

        if (i_resp) begin i_pend = 0; resp_log.push_back(0); end
        if (d_resp) begin d_pend = 0; resp_log.push_back(1); end
        if (auto_i && !i_pend && $urandom_range(0, 99) < req_pct) begin
            i_pend = 1; i_addr_r = rand_addr();
        end
        if (auto_d && !d_pend && $urandom_range(0, 99) < req_pct) begin
            d_pend = 1; d_wr = 1'($urandom_range(0, 1));
            d_both = d_wr && ($urandom_range(0, 9) == 0);
            d_addr_r = rand_addr(); d_wdata_r = rand_line();
        end
        drive_req();

        if (mem_read || mem_write) begin
            mem_resp = ($urandom_range(0, 99) < resp_pct);
            idx = (m_beat < BEATS) ? m_beat : 0;
            tmp = line_of(mem_address);
            mem_burst_i = tmp[BEAT_W*idx +: BEAT_W];
        end else begin
            mem_resp = ($urandom_range(0, 99) < stray_pct);
            mem_burst_i = {$urandom(), $urandom()};
        end

        if (rst) begin
            model_reset();
        end else begin
            n_i = 0; n_d = 0;
            if (m_resp_i || m_resp_d) begin
                m_last = m_resp_d;
            end else if (m_busy) begin
                if (mem_resp) begin
                    if (m_wr) begin
                        check("wr_beat", cv_t'(mem_burst_o), cv_t'(m_line[BEAT_W*m_beat +: BEAT_W]));
                        wcap[BEAT_W*m_beat +: BEAT_W] = mem_burst_o;
                    end
                    m_beat++;
                    if (m_beat == BEATS) begin
                        m_busy = 0;
                        if (m_wr) mem_q[m_addr] = wcap;
                        if (m_port) begin n_d = 1; if (!m_wr) m_rd_d = m_line; end
                        else begin n_i = 1; m_rd_i = m_line; end
                    end
                end
            end else begin
                pi = i_read; pd = d_read || d_write;
                if (pi || pd) begin
                    m_port  = pd && (!pi || !m_last);
                    m_wr    = m_port && d_write;
                    m_addr  = (m_port ? d_address : i_address) & ~ADDR_W'(32'h1f);
                    m_maddr = m_addr;
                    m_line  = m_wr ? d_wdata : line_of(m_addr);
                    m_beat  = 0;
                    m_busy  = 1;
                end
            end
            m_resp_i = n_i; m_resp_d = n_d;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        i_pend = 0; d_pend = 0; rst = 1;
        cycle();
        rst = 0;
    endtask

    // Run until the given port's resp is visible, bounded
    task automatic wait_resp(string tag, bit port);
        int n = 0;
        while (!(port ? d_resp : i_resp) && n < 100) begin cycle(); n++; end
        check(tag, cv_t'(port ? d_resp : i_resp), cv_t'(1));
    endtask

    localparam logic [LINE_W-1:0] IFILL = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [LINE_W-1:0] WB    = {64'hA3A3_0000_3333_A3A3, 64'hA2A2_0000_2222_A2A2,
                                           64'hA1A1_0000_1111_A1A1, 64'hA0A0_0000_0000_A0A0};

    initial begin
        int n;
        logic [LINE_W-1:0] exp_l;
        rst = 1; auto_i = 0; auto_d = 0; i_pend = 0; d_pend = 0; d_wr = 0; d_both = 0;
        i_addr_r = '0; d_addr_r = '0; d_wdata_r = '0;
        req_pct = 0; resp_pct = 100; stray_pct = 0;
        drive_req(); mem_resp = 0; mem_burst_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_burst_o", cv_t'(mem_burst_o), '0);
        rst = 0;

        // reset in the middle of a read burst; memory keeps streaming
        i_pend = 1; i_addr_r = 32'h2040;
        n = 0;
        while (!(m_busy && m_beat == 2) && n < 50) begin cycle(); n++; end
        check("mid_reached", cv_t'(m_busy && m_beat == 2), cv_t'(1));
        i_pend = 0; rst = 1;
        cycle();
        rst = 0; stray_pct = 100;
        cycle(); cycle();
        stray_pct = 0;
        check("mid_rdata", i_rdata, '0);
        i_pend = 1; i_addr_r = 32'h2040;
        wait_resp("mid_refill_resp", 0);
        exp_l = mem_q[32'h2040];
        check("mid_refill_data", i_rdata, exp_l);
        cycle();

        // directed I fill with unaligned address
        mem_q[32'h1220] = IFILL;
        i_pend = 1; i_addr_r = 32'h1234;
        wait_resp("ifill_resp", 0);
        check("ifill_addr", cv_t'(mem_address), cv_t'(32'h1220));
        check("ifill_data", i_rdata, IFILL);
        cycle();

        // directed D writeback then read it back
        d_pend = 1; d_wr = 1; d_both = 0; d_addr_r = 32'h3000; d_wdata_r = WB;
        wait_resp("wb_resp", 1);
        cycle();
        d_pend = 1; d_wr = 0; d_addr_r = 32'h3008;
        wait_resp("wb_readback_resp", 1);
        check("wb_readback", d_rdata, WB);
        cycle();

        // sustained contention from reset: D,I,D,I,D,I
        do_reset();
        resp_log.delete();
        auto_i = 1; auto_d = 1; req_pct = 100;
        n = 0;
        while (resp_log.size() < 6 && n < 200) begin cycle(); n++; end
        check("cont_count", cv_t'(resp_log.size() >= 6), cv_t'(1));
        for (int k = 0; k < 6 && k < resp_log.size(); k++)
            check("cont_order", cv_t'(resp_log[k]), cv_t'((k % 2 == 0) ? 1 : 0));

        // random traffic with memory wait states and stray beats
        req_pct = 30; resp_pct = 70; stray_pct = 25;
        repeat (3000) cycle();
        auto_i = 0; auto_d = 0;
        n = 0;
        while ((i_pend || d_pend) && n < 200) begin cycle(); n++; end
        check("drain", cv_t'(i_pend || d_pend), '0);

        // stray mem_resp while idle, then a clean fill
        stray_pct = 100; resp_pct = 100;
        repeat (5) cycle();
        stray_pct = 0;
        i_pend = 1; i_addr_r = 32'h4567;
        wait_resp("stray_fill_resp", 0);
        exp_l = line_of(32'h4560);
        check("stray_fill_data", i_rdata, exp_l);
        cycle();
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
